// File: rtl/aib_init_pkg.sv
// Shared types for the AIB link bring-up sequencer.
//   state_e    : sequencer FSM states
//   err_code_e : error codes reported on err_code
//   AIB_AW     : AVMM CSR address width
package aib_init_pkg;

    localparam int AIB_AW = 17;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_CFG_WR,
        ST_CFG_GAP,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_POLL_GAP,
        ST_LINK_EN,
        ST_WAIT_LINK,
        ST_ONLINE,
        ST_ERROR
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_WR_TO     = 3'd1,
        ERR_RD_TO     = 3'd2,
        ERR_POLL_TO   = 3'd3,
        ERR_LINK_TO   = 3'd4,
        ERR_LINK_LOST = 3'd5
    } err_code_e;

    // Poll read, wait and retry gap form one phase with a shared watchdog.
    function automatic logic in_poll(input state_e s);
        return (s == ST_POLL_RD) || (s == ST_POLL_WAIT) || (s == ST_POLL_GAP);
    endfunction

endpackage

// File: rtl/aib_avmm_xact.sv
// Single AVMM transfer engine.
//   req_rd/req_wr  : hold high until done (never both)
//   avmm_*         : Avalon-MM master side; addr/wdata/byte_en are zero when idle
//   done           : transfer accepted this cycle (waitreq low)
//   rvld/rdata     : read data return, qualified by the caller
//   timeout        : waitreq held for TIMEOUT_CYC consecutive cycles
module aib_avmm_xact
    import aib_init_pkg::*;
#(
    parameter int AVMM_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [AIB_AW-1:0]     req_addr,
    input  logic [AVMM_WIDTH-1:0] req_wdata,
    output logic [AIB_AW-1:0]     avmm_addr,
    output logic [BYTE_WIDTH-1:0] avmm_byte_en,
    output logic                  avmm_write,
    output logic                  avmm_read,
    output logic [AVMM_WIDTH-1:0] avmm_wdata,
    input  logic                  avmm_waitreq,
    input  logic                  avmm_rdatavld,
    input  logic [AVMM_WIDTH-1:0] avmm_rdata,
    output logic                  done,
    output logic                  rvld,
    output logic [AVMM_WIDTH-1:0] rdata,
    output logic                  timeout
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC - 1);

    logic        active;
    logic [15:0] stall_cnt;

    assign active       = req_rd | req_wr;
    assign avmm_write   = req_wr;
    assign avmm_read    = req_rd & ~req_wr;
    assign avmm_addr    = active ? req_addr : '0;
    assign avmm_wdata   = req_wr ? req_wdata : '0;
    assign avmm_byte_en = active ? '1 : '0;

    assign done    = active & ~avmm_waitreq;
    assign timeout = active & avmm_waitreq & (stall_cnt == TO_LIM);
    assign rvld    = avmm_rdatavld;
    assign rdata   = avmm_rdata;

    // Counts consecutive stalled cycles; cleared by acceptance or idle.
    always_ff @(posedge clk) begin
        if (rst || !active || !avmm_waitreq) stall_cnt <= '0;
        else                                 stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: rtl/aib_link_init_seq.sv
// AIB link bring-up sequencer feeding the AIB-to-AXI bridge leader.
//   start / chnl_en / cfg_* / poll_* : bring-up request, sampled at start
//   o_cfg_avmm_* / i_cfg_avmm_*      : AVMM config master
//   ns_adapter_rstn / ns_mac_rdy     : per-channel controls to the PHY
//   fs_mac_rdy / m_rx_align_done     : per-channel link status
//   busy / link_up / err / err_code  : sequencer status
module aib_link_init_seq
    import aib_init_pkg::*;
#(
    parameter int NBR_CHNLS    = 24,
    parameter int AVMM_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 4,
    parameter int NUM_CFG      = 8,
    parameter int RST_HOLD_CYC = 64,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic                             avmm_clk,
    input  logic                             avmm_rst,
    input  logic                             start,
    input  logic [NBR_CHNLS-1:0]             chnl_en,
    input  logic [$clog2(NUM_CFG+1)-1:0]     cfg_cnt,
    input  logic [AIB_AW*NUM_CFG-1:0]        cfg_addr_tbl,
    input  logic [AVMM_WIDTH*NUM_CFG-1:0]    cfg_data_tbl,
    input  logic [AIB_AW-1:0]                poll_addr,
    input  logic [AVMM_WIDTH-1:0]            poll_mask,
    input  logic [AVMM_WIDTH-1:0]            poll_value,
    output logic [AIB_AW-1:0]                o_cfg_avmm_addr,
    output logic [BYTE_WIDTH-1:0]            o_cfg_avmm_byte_en,
    output logic                             o_cfg_avmm_write,
    output logic                             o_cfg_avmm_read,
    output logic [AVMM_WIDTH-1:0]            o_cfg_avmm_wdata,
    input  logic                             i_cfg_avmm_waitreq,
    input  logic                             i_cfg_avmm_rdatavld,
    input  logic [AVMM_WIDTH-1:0]            i_cfg_avmm_rdata,
    output logic [NBR_CHNLS-1:0]             ns_adapter_rstn,
    output logic [NBR_CHNLS-1:0]             ns_mac_rdy,
    input  logic [NBR_CHNLS-1:0]             fs_mac_rdy,
    input  logic [NBR_CHNLS-1:0]             m_rx_align_done,
    output logic                             busy,
    output logic                             link_up,
    output logic                             err,
    output logic [2:0]                       err_code
);

    localparam int          CW        = $clog2(NUM_CFG + 1);
    localparam int          SW        = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam logic [15:0] TO_LIM    = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] HOLD_LIM  = 16'(RST_HOLD_CYC - 1);
    localparam logic [CW-1:0] CFG_MAX = CW'(NUM_CFG);

    state_e    state_q, state_d;
    err_code_e code_q, code_d;
    logic      err_q;
    logic [CW-1:0] idx_q, cnt_q;
    logic [SW-1:0] idx_s;
    logic [15:0]   wdog_q;

    logic [NBR_CHNLS-1:0]                   en_q;
    logic [NUM_CFG-1:0][AIB_AW-1:0]         addr_q;
    logic [NUM_CFG-1:0][AVMM_WIDTH-1:0]     data_q;
    logic [AIB_AW-1:0]                      paddr_q;
    logic [AVMM_WIDTH-1:0]                  pmask_q, pval_q;

    logic x_rd, x_wr, x_done, x_rvld, x_to;
    logic [AVMM_WIDTH-1:0] x_rdata;
    logic start_ok, link_ok, poll_hit, wdog_clr, wdog_run;

    assign idx_s    = idx_q[SW-1:0];
    assign x_wr     = (state_q == ST_CFG_WR);
    assign x_rd     = (state_q == ST_POLL_RD);
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
    assign link_ok  = ((fs_mac_rdy & m_rx_align_done & en_q) == en_q);
    assign poll_hit = ((x_rdata & pmask_q) == pval_q);

    aib_avmm_xact #(
        .AVMM_WIDTH (AVMM_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_xact (
        .clk          (avmm_clk),
        .rst          (avmm_rst),
        .req_rd       (x_rd),
        .req_wr       (x_wr),
        .req_addr     (x_wr ? addr_q[idx_s] : paddr_q),
        .req_wdata    (data_q[idx_s]),
        .avmm_addr    (o_cfg_avmm_addr),
        .avmm_byte_en (o_cfg_avmm_byte_en),
        .avmm_write   (o_cfg_avmm_write),
        .avmm_read    (o_cfg_avmm_read),
        .avmm_wdata   (o_cfg_avmm_wdata),
        .avmm_waitreq (i_cfg_avmm_waitreq),
        .avmm_rdatavld(i_cfg_avmm_rdatavld),
        .avmm_rdata   (i_cfg_avmm_rdata),
        .done         (x_done),
        .rvld         (x_rvld),
        .rdata        (x_rdata),
        .timeout      (x_to)
    );

    always_comb begin
        state_d = state_q;
        code_d  = ERR_NONE;
        case (state_q)
            ST_IDLE, ST_ERROR: if (start) state_d = ST_RST_HOLD;
            ST_RST_HOLD:
                if (wdog_q == HOLD_LIM) state_d = (cnt_q == '0) ? ST_POLL_RD : ST_CFG_WR;
            ST_CFG_WR:
                if (x_to) begin
                    state_d = ST_ERROR; code_d = ERR_WR_TO;
                end else if (x_done) begin
                    state_d = (idx_q == cnt_q - CW'(1)) ? ST_POLL_RD : ST_CFG_GAP;
                end
            ST_CFG_GAP: state_d = ST_CFG_WR;
            ST_POLL_RD:
                if (x_to) begin
                    state_d = ST_ERROR; code_d = ERR_RD_TO;
                end else if (wdog_q == TO_LIM) begin
                    state_d = ST_ERROR; code_d = ERR_POLL_TO;
                end else if (x_done) begin
                    state_d = ST_POLL_WAIT;
                end
            ST_POLL_WAIT:
                if (x_rvld) begin
                    state_d = poll_hit ? ST_LINK_EN : ST_POLL_GAP;
                end else if (wdog_q == TO_LIM) begin
                    state_d = ST_ERROR; code_d = ERR_POLL_TO;
                end
            ST_POLL_GAP:
                if (wdog_q == TO_LIM) begin
                    state_d = ST_ERROR; code_d = ERR_POLL_TO;
                end else begin
                    state_d = ST_POLL_RD;
                end
            ST_LINK_EN: state_d = ST_WAIT_LINK;
            ST_WAIT_LINK:
                if (link_ok) begin
                    state_d = ST_ONLINE;
                end else if (wdog_q == TO_LIM) begin
                    state_d = ST_ERROR; code_d = ERR_LINK_TO;
                end
            ST_ONLINE:
                if (!link_ok) begin
                    state_d = ST_ERROR; code_d = ERR_LINK_LOST;
                end
            default: state_d = ST_IDLE;
        endcase
    end

    // The poll watchdog spans all retries, so moving between poll states
    // does not clear it; write/read stalls are timed inside the xact engine.
    assign wdog_clr = (state_d != state_q) && !(in_poll(state_d) && in_poll(state_q));
    assign wdog_run = (state_q == ST_RST_HOLD) || in_poll(state_q) || (state_q == ST_WAIT_LINK);

    always_ff @(posedge avmm_clk) begin
        if (avmm_rst) begin
            state_q <= ST_IDLE;
            wdog_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            if (wdog_clr)      wdog_q <= '0;
            else if (wdog_run) wdog_q <= wdog_q + 16'd1;

            if (start_ok)                 idx_q <= '0;
            else if (x_wr && x_done)      idx_q <= idx_q + CW'(1);

            if (start_ok) begin
                cnt_q  <= (cfg_cnt > CFG_MAX) ? CFG_MAX : cfg_cnt;
                en_q   <= chnl_en;
                err_q  <= 1'b0;
                code_q <= ERR_NONE;
            end else if (state_d == ST_ERROR && state_q != ST_ERROR) begin
                err_q  <= 1'b1;
                code_q <= code_d;
            end
        end
    end

    // Table and poll compare values only matter after start; no reset needed.
    always_ff @(posedge avmm_clk) begin
        if (start_ok) begin
            addr_q  <= cfg_addr_tbl;
            data_q  <= cfg_data_tbl;
            paddr_q <= poll_addr;
            pmask_q <= poll_mask;
            pval_q  <= poll_value;
        end
    end

    always_comb begin
        ns_adapter_rstn = '0;
        ns_mac_rdy      = '0;
        case (state_q)
            ST_LINK_EN:              ns_adapter_rstn = en_q;
            ST_WAIT_LINK, ST_ONLINE: begin
                ns_adapter_rstn = en_q;
                ns_mac_rdy      = en_q;
            end
            default: ;
        endcase
    end

    assign busy     = !((state_q == ST_IDLE) || (state_q == ST_ONLINE) || (state_q == ST_ERROR));
    assign link_up  = (state_q == ST_ONLINE);
    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_aib_link_init_seq.sv
// Directed bench for aib_link_init_seq with a small AVMM PHY responder.
module tb_aib_link_init_seq;

    localparam int NC = 24;
    localparam int DW = 32;
    localparam int NCFG = 8;

    logic            avmm_clk = 1'b0;
    logic            avmm_rst = 1'b1;
    logic            start = 1'b0;
    logic [NC-1:0]   chnl_en = '0;
    logic [3:0]      cfg_cnt = '0;
    logic [17*NCFG-1:0] cfg_addr_tbl = '0;
    logic [DW*NCFG-1:0] cfg_data_tbl = '0;
    logic [16:0]     poll_addr = '0;
    logic [DW-1:0]   poll_mask = '0;
    logic [DW-1:0]   poll_value = '0;
    logic [16:0]     addr;
    logic [3:0]      byte_en;
    logic            write, read;
    logic [DW-1:0]   wdata;
    logic            waitreq;
    logic            rdatavld = 1'b0;
    logic [DW-1:0]   rdata = '0;
    logic [NC-1:0]   rstn, mac_rdy;
    logic [NC-1:0]   fs_rdy = '0;
    logic [NC-1:0]   align = '0;
    logic            busy, link_up, err;
    logic [2:0]      err_code;

    aib_link_init_seq #(
        .NBR_CHNLS(NC), .AVMM_WIDTH(DW), .BYTE_WIDTH(4), .NUM_CFG(NCFG),
        .RST_HOLD_CYC(8), .TIMEOUT_CYC(100)
    ) dut (
        .avmm_clk(avmm_clk), .avmm_rst(avmm_rst), .start(start), .chnl_en(chnl_en),
        .cfg_cnt(cfg_cnt), .cfg_addr_tbl(cfg_addr_tbl), .cfg_data_tbl(cfg_data_tbl),
        .poll_addr(poll_addr), .poll_mask(poll_mask), .poll_value(poll_value),
        .o_cfg_avmm_addr(addr), .o_cfg_avmm_byte_en(byte_en),
        .o_cfg_avmm_write(write), .o_cfg_avmm_read(read), .o_cfg_avmm_wdata(wdata),
        .i_cfg_avmm_waitreq(waitreq), .i_cfg_avmm_rdatavld(rdatavld),
        .i_cfg_avmm_rdata(rdata), .ns_adapter_rstn(rstn), .ns_mac_rdy(mac_rdy),
        .fs_mac_rdy(fs_rdy), .m_rx_align_done(align), .busy(busy),
        .link_up(link_up), .err(err), .err_code(err_code)
    );

    always #5 avmm_clk = ~avmm_clk;

    // PHY responder state
    int          wr_cnt = 0, rd_cnt = 0, rv_cnt = 0, stall_cyc = 0, stall_bad = 0;
    int          stall_at = -1, stall_len = 0;
    logic [16:0] stall_ref_addr = '0;
    logic [DW-1:0] stall_ref_data = '0, rv_data = '0;
    logic [16:0] wlog_addr [0:63];
    logic [DW-1:0] wlog_data [0:63];
    logic [DW-1:0] resp [0:15];

    assign waitreq = write && (wr_cnt == stall_at) && (stall_cyc < stall_len);

    always @(posedge avmm_clk) begin
        rdatavld <= (rv_cnt == 1);
        rdata    <= (rv_cnt == 1) ? rv_data : '0;
        rv_cnt   <= (rv_cnt > 0) ? rv_cnt - 1 : 0;
        if (write && waitreq) begin
            stall_cyc <= stall_cyc + 1;
            if (addr !== stall_ref_addr || wdata !== stall_ref_data) stall_bad <= stall_bad + 1;
        end
        if (write && !waitreq) begin
            wlog_addr[wr_cnt % 64] <= addr;
            wlog_data[wr_cnt % 64] <= wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (read && !waitreq) begin
            rd_cnt  <= rd_cnt + 1;
            rv_cnt  <= 2;
            rv_data <= resp[rd_cnt % 16];
        end
    end

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge avmm_clk);
        #1;
    endtask

    function automatic logic [16:0] ea(input int i);
        return 17'h100 + 17'(i);
    endfunction

    function automatic logic [DW-1:0] ed(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h11;
    endfunction

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_mac(input int bound);
        int n = 0;
        while (mac_rdy[0] !== 1'b1 && n < bound) begin tick; n++; end
    endtask

    task automatic wait_link(input int bound);
        int n = 0;
        while (link_up !== 1'b1 && n < bound) begin tick; n++; end
    endtask

    int wr0, rd0, n;

    initial begin
        for (int i = 0; i < 16; i++) resp[i] = 32'h1;
        resp[1] = 32'h0;
        resp[2] = 32'h0;
        for (int i = 0; i < NCFG; i++) begin
            cfg_addr_tbl[17*i +: 17] = ea(i);
            cfg_data_tbl[DW*i +: DW] = ed(i);
        end
        poll_addr = 17'h1F0; poll_mask = 32'h1; poll_value = 32'h1;

        // reset state
        repeat (3) tick;
        chk("rst_write", 64'(write), 0);
        chk("rst_read", 64'(read), 0);
        chk("rst_addr", 64'(addr), 0);
        chk("rst_byte_en", 64'(byte_en), 0);
        chk("rst_wdata", 64'(wdata), 0);
        chk("rst_rstn", 64'(rstn), 0);
        chk("rst_mac_rdy", 64'(mac_rdy), 0);
        chk("rst_status", 64'({busy, link_up, err, err_code}), 0);
        avmm_rst = 1'b0;
        tick;

        // Run A: 3 writes, single poll, channel 0, far side ready 5 cycles late
        cfg_cnt = 4'd3; chnl_en = 24'h1;
        wr0 = wr_cnt; rd0 = rd_cnt;
        pulse_start;
        chk("a_busy", 64'(busy), 1);
        chk("a_rstn_hold", 64'(rstn), 0);
        n = 0;
        while (!write && n < 50) begin tick; n++; end
        chk("a_hold_len", 64'(n), 8);
        chk("a_first_addr", 64'(addr), 64'(ea(0)));
        chk("a_byte_en", 64'(byte_en), 64'hF);
        wait_mac(300);
        chk("a_mac_rdy", 64'(mac_rdy), 1);
        chk("a_rstn_rel", 64'(rstn), 1);
        chk("a_wr_count", 64'(wr_cnt - wr0), 3);
        chk("a_rd_count", 64'(rd_cnt - rd0), 1);
        for (int i = 0; i < 3; i++) begin
            chk("a_wr_addr", 64'(wlog_addr[wr0 + i]), 64'(ea(i)));
            chk("a_wr_data", 64'(wlog_data[wr0 + i]), 64'(ed(i)));
        end
        repeat (5) tick;
        chk("a_no_link_yet", 64'(link_up), 0);
        fs_rdy = '1; align = '1;
        wait_link(10);
        chk("a_link_up", 64'(link_up), 1);
        chk("a_busy_online", 64'(busy), 0);
        chk("a_err", 64'(err), 0);
        pulse_start;
        chk("a_start_online_ignored", 64'({busy, link_up}), 64'b01);

        // Link loss in ONLINE
        align = 24'hFFFFFE;
        tick;
        chk("loss_code", 64'(err_code), 5);
        chk("loss_err", 64'(err), 1);
        chk("loss_link", 64'(link_up), 0);
        chk("loss_mac_rstn", 64'({mac_rdy, rstn}), 0);

        // Run B: 2nd write stalls 4 cycles, status 0,0,1
        fs_rdy = '0; align = '0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        stall_at = wr_cnt + 1; stall_len = 4;
        stall_ref_addr = ea(1); stall_ref_data = ed(1);
        pulse_start;
        chk("b_err_cleared", 64'({err, err_code}), 0);
        chk("b_busy", 64'(busy), 1);
        wait_mac(300);
        chk("b_wr_count", 64'(wr_cnt - wr0), 3);
        chk("b_stall_cycles", 64'(stall_cyc), 4);
        chk("b_stall_stable", 64'(stall_bad), 0);
        chk("b_wr1_addr", 64'(wlog_addr[wr0 + 1]), 64'(ea(1)));
        chk("b_wr2_data", 64'(wlog_data[wr0 + 2]), 64'(ed(2)));
        chk("b_rd_count", 64'(rd_cnt - rd0), 3);
        fs_rdy = '1; align = '1;
        wait_link(10);
        chk("b_link_up", 64'(link_up), 1);
        fs_rdy = 24'hFFFFFE;
        tick;
        chk("b_loss_code", 64'(err_code), 5);

        // Run C: no writes, far side never ready -> link timeout at cycle 100
        fs_rdy = '0; align = '0;
        cfg_cnt = 4'd0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        pulse_start;
        wait_mac(300);
        chk("c_wr_count", 64'(wr_cnt - wr0), 0);
        chk("c_rd_count", 64'(rd_cnt - rd0), 1);
        repeat (99) tick;
        chk("c_before_to", 64'({err, mac_rdy[0]}), 64'b01);
        tick;
        chk("c_to_err", 64'(err), 1);
        chk("c_to_code", 64'(err_code), 4);
        chk("c_to_mac_rstn", 64'({mac_rdy, rstn}), 0);
        chk("c_to_busy", 64'(busy), 0);

        // Run D: cfg_cnt clamp, chnl_en = 0, start while busy ignored
        cfg_cnt = 4'd12; chnl_en = '0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        pulse_start;
        n = 0;
        while (!write && n < 50) begin
            if (n == 3) start = 1'b1;
            tick;
            start = 1'b0;
            n++;
        end
        chk("d_busy_start_ignored", 64'(n), 8);
        wait_link(300);
        chk("d_link_up", 64'(link_up), 1);
        chk("d_wr_clamped", 64'(wr_cnt - wr0), 8);
        chk("d_wr7_addr", 64'(wlog_addr[wr0 + 7]), 64'(ea(7)));
        chk("d_wr7_data", 64'(wlog_data[wr0 + 7]), 64'(ed(7)));
        chk("d_chnl_off", 64'({mac_rdy, rstn}), 0);

        // Run E: reset while a write is stalled
        avmm_rst = 1'b1;
        tick;
        avmm_rst = 1'b0;
        chk("e_rst_from_online", 64'(link_up), 0);
        cfg_cnt = 4'd2; chnl_en = 24'h1;
        stall_at = wr_cnt; stall_len = 1000;
        pulse_start;
        n = 0;
        while (!write && n < 50) begin tick; n++; end
        repeat (2) tick;
        chk("e_stalled_write", 64'({write, waitreq}), 64'b11);
        avmm_rst = 1'b1;
        tick;
        chk("e_strobes", 64'({write, read}), 0);
        chk("e_addr_data_be", 64'({addr, wdata, byte_en}), 0);
        chk("e_chnl", 64'({mac_rdy, rstn}), 0);
        chk("e_status", 64'({busy, link_up, err, err_code}), 0);
        stall_len = 0;
        avmm_rst = 1'b0;
        wr0 = wr_cnt;
        pulse_start;
        n = 0;
        while (!read && n < 100) begin tick; n++; end
        chk("e_rerun_wr_count", 64'(wr_cnt - wr0), 2);
        chk("e_rerun_idx0", 64'(wlog_addr[wr0]), 64'(ea(0)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
